frame_buffer_writer: RTL and testbench
======================================

# frame_buffer_writer

Captures one 16×16 frame of 16-bit pixels, addressed by the 4-bit column/row coordinates the image controller produces, into an on-chip 256×16 buffer. Once the frame is complete it streams the buffer out in raster order over a valid/ready interface. It sits directly downstream of the image controller and upstream of the output serializer.

## Interface
Parameters:
- IMG_DIM, 16: pixels per row and rows per frame. Only 16 is supported; it sets 4-bit coordinates and a 256-word buffer.
- PIX_W, 16: pixel width in bits.

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- nrst  in  1  reset. Asynchronous and active-low.
- clear  in  1  synchronous abort. Returns the block to IDLE.
- pix_valid  in  1  write strobe, one pixel per cycle.
- x  in  4  column coordinate (controller `left`).
- y  in  4  row coordinate (controller `right`).
- pixel_in  in  16  pixel data (controller `data_out`).
- out_ready  in  1  downstream accepts a word.
- out_valid  out  1  out_data is valid.
- out_data  out  16  streamed word.
- out_last  out  1  marks the final word of the frame stream.
- busy  out  1  high in FILL or DRAIN.
- frame_done  out  1  one-cycle pulse after the final word is accepted.
- overflow  out  1  sticky. A pixel arrived during DRAIN.
- sync_err  out  1  sticky. A pixel arrived in IDLE at a coordinate other than (0,0).

## Operation
- Buffer address is {y,x}; row-major, x fastest.
- **IDLE:**
  - pix_valid at (0,0): write the pixel and go to FILL.
  - pix_valid at any other coordinate: drop the pixel and set sync_err.
- **FILL:**
  - Every pix_valid writes pixel_in to {y,x}.
  - A repeated coordinate overwrites the earlier pixel with no error. Missing coordinates keep stale contents.
  - A write at (15,15) moves to DRAIN on the next cycle.
- **DRAIN:**
  - Reads addresses 0..255 in order and presents each on out_data.
  - A word transfers when out_valid && out_ready.
  - While out_valid && !out_ready, out_data, out_last and out_valid hold stable.
  - pix_valid in DRAIN: drop the pixel and set overflow.
  - After the last transfer: return to IDLE and pulse frame_done.
- **clear:**
  - Forces IDLE on the next edge and drops out_valid.
  - Clears overflow and sync_err.
  - Does not erase buffer contents.
  - clear wins over a simultaneous pix_valid or handshake.
- Reset mid-frame behaves like clear and also zeroes all outputs.

## Timing
- Reset values:
  - state = IDLE.
  - out_valid, out_last, busy, frame_done, overflow, sync_err = 0.
  - out_data = 0.
- busy rises the cycle after the (0,0) write and falls the cycle after the final transfer.
- Buffer read is synchronous, with 1-cycle latency. A one-entry prefetch register hides it.
- First out_valid is asserted on the 2nd cycle in DRAIN.
- With out_ready held high the block streams one word per cycle: 256 words in 256 consecutive cycles.
- out_ready dropping for N cycles stalls the stream for exactly N cycles. No word is lost or duplicated.
- frame_done pulses on the cycle after the final transfer, coincident with busy falling.
- Write-to-read latency: a pixel written in the (15,15) cycle is readable in DRAIN. There is no read-before-write hazard.

## Configuration
- FRAME_CHECKSUM_EN defined:
  - A 16-bit wrap-around sum of every pixel written during FILL, including overwrites.
  - The sum resets to 0 on entry to FILL (the (0,0) pixel is its first term).
  - It is appended as word 257 after address 255.
  - out_last is asserted on the checksum word only.
- FRAME_CHECKSUM_EN undefined:
  - The stream is exactly 256 words.
  - out_last is asserted on address 255.
  - No checksum logic is present.

## Structure
- Shared package `image_pkg` holds:
  - IMG_DIM, PIX_W and FRAME_WORDS = 256.
  - typedefs coord_t (logic [3:0]) and pixel_t (logic [15:0]).
  - enum fbw_state_t {IDLE, FILL, DRAIN}.
- Sub-module `frame_ram`: 256×16 single-clock RAM with one write port and one synchronous read port, no reset on the array. The FSM, prefetch register and checksum stay in `frame_buffer_writer`.

## Test plan
- **Full frame:** write pixel = {y,x}·3 for all 256 coordinates with out_ready = 1. Expect 256 words in order, word k = k·3; out_last on word 255; frame_done one cycle later.
- **Backpressure:** toggle out_ready at random during DRAIN. Expect out_data stable while stalled and an identical word sequence, with no drops or duplicates.
- **Sync error:** pix_valid at (3,0) while in IDLE. Expect no state change, sync_err = 1, busy = 0. A following write at (0,0) enters FILL.
- **Overflow:** pix_valid pulses during DRAIN. Expect overflow = 1 and stream contents unchanged.
- **Abort:** clear at pixel 100 of FILL. Expect IDLE next cycle, busy = 0, flags cleared, no out_valid. The next full frame streams correctly.
- **Checksum (FRAME_CHECKSUM_EN):** write all pixels = 16'h0101. Expect word 257 = 16'h0100 (256·0x0101 mod 2^16), with out_last only on word 257.

Source files
------------

// File: rtl/image_pkg.sv
// Shared types and constants for the image pipeline (frame size, pixel width, writer FSM states).
package image_pkg;

    localparam int unsigned IMG_DIM     = 16;
    localparam int unsigned PIX_W       = 16;
    localparam int unsigned FRAME_WORDS = 256;

    typedef logic [3:0]  coord_t;
    typedef logic [15:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } fbw_state_t;

endpackage

// File: rtl/frame_ram.sv
// Single-clock frame store: one write port, one registered read port, no reset on the array.
module frame_ram #(
    parameter int unsigned Depth = 256,
    parameter int unsigned Width = 16,
    parameter int unsigned AddrW = 8
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port; the output register holds its word while re_i is low.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer_writer.sv
// Captures one 16x16 frame into frame_ram, then streams it out in raster order over valid/ready.
// Optional feature: define FRAME_CHECKSUM_EN to append a 16-bit sum of all FILL writes as the
// final stream word.
module frame_buffer_writer
    import image_pkg::*;
#(
    parameter int unsigned IMG_DIM = 16,
    parameter int unsigned PIX_W   = 16
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       clear,
    input  logic                       pix_valid,
    input  logic [$clog2(IMG_DIM)-1:0] x,
    input  logic [$clog2(IMG_DIM)-1:0] y,
    input  logic [PIX_W-1:0]           pixel_in,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [PIX_W-1:0]           out_data,
    output logic                       out_last,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       overflow,
    output logic                       sync_err
);

    localparam int unsigned CoordW = $clog2(IMG_DIM);
    localparam int unsigned AddrW  = 2 * CoordW;
    localparam int unsigned Words  = IMG_DIM * IMG_DIM;
    localparam int unsigned CntW   = AddrW + 1;
`ifdef FRAME_CHECKSUM_EN
    localparam int unsigned StreamWords = Words + 1;
`else
    localparam int unsigned StreamWords = Words;
`endif
    localparam logic [CntW-1:0] LastIdx = CntW'(StreamWords - 1);
    localparam logic [CntW-1:0] EndIdx  = CntW'(StreamWords);

    fbw_state_t       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;          // words issued to the output register so far
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             frame_done_q, frame_done_d;
    logic             overflow_q, overflow_d;
    logic             sync_err_q, sync_err_d;
    logic             ram_we, ram_re;
    logic [PIX_W-1:0] ram_rdata, word;
    logic             origin, corner;
`ifdef FRAME_CHECKSUM_EN
    logic [PIX_W-1:0] csum_q, csum_d;
    logic             csum_sel_q, csum_sel_d;
`endif

    assign origin = (x == '0) && (y == '0);
    assign corner = (x == '1) && (y == '1);

    frame_ram #(
        .Depth (Words),
        .Width (PIX_W),
        .AddrW (AddrW)
    ) u_frame_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i ({y, x}),
        .wdata_i (pixel_in),
        .re_i    (ram_re),
        .raddr_i (cnt_q[AddrW-1:0]),
        .rdata_o (ram_rdata)
    );

    // Next-state: capture, drain with the RAM read register as prefetch stage, abort.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        sync_err_d   = sync_err_q;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        csum_d       = csum_q;
        csum_sel_d   = csum_sel_q;
`endif
        if (clear) begin
            state_d     = IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            overflow_d  = 1'b0;
            sync_err_d  = 1'b0;
`ifdef FRAME_CHECKSUM_EN
            csum_sel_d  = 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pix_valid) begin
                        if (origin) begin
                            ram_we  = 1'b1;
                            state_d = FILL;
`ifdef FRAME_CHECKSUM_EN
                            csum_d  = pixel_in;
`endif
                        end else begin
                            sync_err_d = 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (pix_valid) begin
                        ram_we = 1'b1;
`ifdef FRAME_CHECKSUM_EN
                        csum_d = csum_q + pixel_in;
`endif
                        if (corner) begin
                            state_d = DRAIN;
                            cnt_d   = '0;
                        end
                    end
                end
                DRAIN: begin
                    if (pix_valid) begin
                        overflow_d = 1'b1;
                    end
                    if (out_valid_q && out_ready && out_last_q) begin
                        state_d      = IDLE;
                        cnt_d        = '0;
                        out_valid_d  = 1'b0;
                        out_last_d   = 1'b0;
                        frame_done_d = 1'b1;
`ifdef FRAME_CHECKSUM_EN
                        csum_sel_d   = 1'b0;
`endif
                    end else if ((!out_valid_q || out_ready) && (cnt_q != EndIdx)) begin
                        // Output slot is free or being emptied: fetch the next word into it.
                        ram_re      = ~cnt_q[AddrW];
                        out_valid_d = 1'b1;
                        out_last_d  = (cnt_q == LastIdx);
                        cnt_d       = cnt_q + 1'b1;
`ifdef FRAME_CHECKSUM_EN
                        csum_sel_d  = cnt_q[AddrW];
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and flag registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            sync_err_q   <= sync_err_d;
        end
    end

`ifdef FRAME_CHECKSUM_EN
    // Running checksum and checksum-word select.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            csum_q     <= '0;
            csum_sel_q <= 1'b0;
        end else begin
            csum_q     <= csum_d;
            csum_sel_q <= csum_sel_d;
        end
    end

    assign word = csum_sel_q ? csum_q : ram_rdata;
`else
    assign word = ram_rdata;
`endif

    // RAM read register is not reset, so gate the data bus while no word is presented.
    assign out_data   = out_valid_q ? word : '0;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed self-checking bench for frame_buffer_writer; checksum case built with FRAME_CHECKSUM_EN.
module tb_frame_buffer_writer;

    logic        clk = 1'b0;
    logic        nrst, clear, pix_valid, out_ready;
    logic [3:0]  x, y;
    logic [15:0] pixel_in, out_data;
    logic        out_valid, out_last, busy, frame_done, overflow, sync_err;

    int checks = 0;
    int errors = 0;

`ifdef FRAME_CHECKSUM_EN
    localparam int NWords = 257;
`else
    localparam int NWords = 256;
`endif

    // Reference memory and checksum, updated by the bench as it writes pixels.
    logic [15:0] mdl [0:255];
    logic [15:0] mdl_sum = 16'h0;

    logic [15:0] got [0:299];
    int got_n, nlast, last_idx, first_valid_c, first_xfer_c, last_xfer_c, done_c, stall_n;
    int stable_bad;
    logic busy_at_done;

    frame_buffer_writer #(
        .IMG_DIM (16),
        .PIX_W   (16)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .clear      (clear),
        .pix_valid  (pix_valid),
        .x          (x),
        .y          (y),
        .pixel_in   (pixel_in),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pix_of(input int mode, input int k);
        case (mode)
            0:       return 16'(k * 3);
            1:       return 16'h0101;
            default: return 16'(k) ^ 16'hA5A5;
        endcase
    endfunction

    function automatic logic [15:0] exp_word(input int i);
        if (i < 256) return mdl[i];
        return mdl_sum;
    endfunction

    task automatic put(input int k, input logic [15:0] p, input bit restart);
        @(negedge clk);
        pix_valid = 1'b1;
        x         = 4'(k);
        y         = 4'(k >> 4);
        pixel_in  = p;
        mdl[k]    = p;
        mdl_sum   = restart ? p : 16'(mdl_sum + p);
    endtask

    task automatic end_writes();
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic fill(input int mode);
        for (int k = 0; k < 256; k++) put(k, pix_of(mode, k), k == 0);
        end_writes();
    endtask

    // Collect the stream; mode 0: ready high, 1: random ready, 2: ready high + pixel pulses.
    task automatic drain(input int mode);
        bit          stalled;
        logic [15:0] prev_data;
        logic        prev_last;
        got_n = 0; nlast = 0; last_idx = -1; first_valid_c = -1; first_xfer_c = -1;
        last_xfer_c = -1; done_c = -1; stall_n = 0; stable_bad = 0; busy_at_done = 1'b1;
        stalled = 1'b0; prev_data = '0; prev_last = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) @(negedge clk);
            if (frame_done === 1'b1) begin
                done_c = c;
                busy_at_done = busy;
                break;
            end
            if (stalled && (out_valid !== 1'b1 || out_data !== prev_data ||
                            out_last !== prev_last)) stable_bad++;
            if (out_valid === 1'b1 && first_valid_c < 0) first_valid_c = c;
            out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mode == 2) begin
                pix_valid = (c % 37 == 5);
                x = 4'd7; y = 4'd7; pixel_in = 16'hDEAD;
            end
            stalled = 1'b0;
            if (out_valid === 1'b1 && out_ready) begin
                if (got_n < 300) got[got_n] = out_data;
                if (first_xfer_c < 0) first_xfer_c = c;
                if (out_last === 1'b1) begin
                    nlast++;
                    last_idx = got_n;
                    last_xfer_c = c;
                end
                got_n++;
            end else if (out_valid === 1'b1) begin
                stalled = 1'b1;
                prev_data = out_data;
                prev_last = out_last;
                if (first_xfer_c >= 0) stall_n++;
            end
        end
        pix_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        nrst = 1'b0; clear = 1'b0; pix_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; pixel_in = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_last, busy, frame_done, overflow, sync_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000",
                     {out_valid, out_last, busy, frame_done, overflow, sync_err});
        end
        checks++;
        if (out_data !== 16'h0) begin
            errors++; $display("FAIL reset_data got %h want 0000", out_data);
        end
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b want 0", busy); end
    endtask

    task automatic test_full_frame();
        fill(0);
        drain(0);
        checks++;
        if (done_c < 0) begin errors++; $display("FAIL ff_timeout got no frame_done want pulse"); end
        checks++;
        if (got_n !== NWords) begin
            errors++; $display("FAIL ff_count got %0d want %0d", got_n, NWords);
        end
        for (int i = 0; i < got_n && i < NWords; i++) begin
            checks++;
            if (got[i] !== exp_word(i)) begin
                errors++; $display("FAIL ff_word[%0d] got %h want %h", i, got[i], exp_word(i));
            end
        end
        checks++;
        if (got[255] !== 16'h02FD) begin
            errors++; $display("FAIL ff_word255 got %h want 02fd", got[255]);
        end
        checks++;
        if (nlast !== 1 || last_idx !== NWords - 1) begin
            errors++; $display("FAIL ff_last got n=%0d idx=%0d want n=1 idx=%0d",
                               nlast, last_idx, NWords - 1);
        end
        checks++;
        if (first_valid_c !== 1) begin
            errors++; $display("FAIL ff_first_valid got cycle %0d want 1", first_valid_c);
        end
        checks++;
        if (last_xfer_c - first_xfer_c + 1 !== NWords) begin
            errors++; $display("FAIL ff_throughput got %0d cycles want %0d",
                               last_xfer_c - first_xfer_c + 1, NWords);
        end
        checks++;
        if (done_c !== last_xfer_c + 1) begin
            errors++; $display("FAIL ff_done_timing got %0d want %0d", done_c, last_xfer_c + 1);
        end
        checks++;
        if (busy_at_done !== 1'b0) begin
            errors++; $display("FAIL ff_busy_fall got %b want 0", busy_at_done);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++; $display("FAIL ff_done_pulse got %b want 0", frame_done);
        end
    endtask

    task automatic test_sync_err();
        @(negedge clk);
        pix_valid = 1'b1; x = 4'd3; y = 4'd0; pixel_in = 16'h1234;
        @(negedge clk);
        pix_valid = 1'b0;
        checks++;
        if (sync_err !== 1'b1) begin errors++; $display("FAIL se_flag got %b want 1", sync_err); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL se_busy got %b want 0", busy); end
        put(0, pix_of(0, 0), 1'b1);
        end_writes();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL se_enter_fill got %b want 1", busy); end
        for (int k = 1; k < 256; k++) put(k, pix_of(0, k), 1'b0);
        end_writes();
        drain(0);
        checks++;
        if (got_n !== NWords) begin
            errors++; $display("FAIL se_count got %0d want %0d", got_n, NWords);
        end
        checks++;
        if (got[3] !== 16'h0009) begin errors++; $display("FAIL se_word3 got %h want 0009", got[3]); end
        checks++;
        if (sync_err !== 1'b1) begin errors++; $display("FAIL se_sticky got %b want 1", sync_err); end
    endtask

    task automatic test_backpressure();
        fill(2);
        drain(1);
        checks++;
        if (got_n !== NWords) begin
            errors++; $display("FAIL bp_count got %0d want %0d", got_n, NWords);
        end
        for (int i = 0; i < got_n && i < NWords; i++) begin
            checks++;
            if (got[i] !== exp_word(i)) begin
                errors++; $display("FAIL bp_word[%0d] got %h want %h", i, got[i], exp_word(i));
            end
        end
        checks++;
        if (stable_bad !== 0) begin
            errors++; $display("FAIL bp_stable got %0d changes want 0", stable_bad);
        end
        checks++;
        if (last_xfer_c - first_xfer_c + 1 !== NWords + stall_n) begin
            errors++; $display("FAIL bp_stall_len got %0d cycles want %0d",
                               last_xfer_c - first_xfer_c + 1, NWords + stall_n);
        end
    endtask

    task automatic test_overflow();
        fill(0);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ov_pre got %b want 0", overflow); end
        drain(2);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ov_flag got %b want 1", overflow); end
        checks++;
        if (got_n !== NWords) begin
            errors++; $display("FAIL ov_count got %0d want %0d", got_n, NWords);
        end
        for (int i = 0; i < got_n && i < NWords; i++) begin
            checks++;
            if (got[i] !== exp_word(i)) begin
                errors++; $display("FAIL ov_word[%0d] got %h want %h", i, got[i], exp_word(i));
            end
        end
    endtask

    task automatic test_abort();
        for (int k = 0; k < 100; k++) put(k, 16'h0101, k == 0);
        @(negedge clk);
        clear = 1'b1; pix_valid = 1'b1; x = 4'd4; y = 4'd6; pixel_in = 16'h5555;
        @(negedge clk);
        clear = 1'b0; pix_valid = 1'b0;
        checks++;
        if ({busy, out_valid, overflow, sync_err} !== 4'b0) begin
            errors++; $display("FAIL ab_state got %b want 0000",
                               {busy, out_valid, overflow, sync_err});
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, out_valid} !== 2'b0) begin
            errors++; $display("FAIL ab_idle got %b want 00", {busy, out_valid});
        end
    endtask

    task automatic test_stale();
        put(0, 16'h1111, 1'b1);
        put(5, 16'h2222, 1'b0);
        put(5, 16'h3333, 1'b0);
        put(255, 16'h4444, 1'b0);
        end_writes();
        drain(0);
        checks++;
        if (got_n !== NWords) begin
            errors++; $display("FAIL st_count got %0d want %0d", got_n, NWords);
        end
        for (int i = 0; i < got_n && i < NWords; i++) begin
            checks++;
            if (got[i] !== exp_word(i)) begin
                errors++; $display("FAIL st_word[%0d] got %h want %h", i, got[i], exp_word(i));
            end
        end
        checks++;
        if (got[5] !== 16'h3333) begin errors++; $display("FAIL st_overwrite got %h want 3333", got[5]); end
        checks++;
        if (got[100] !== 16'h012C) begin
            errors++; $display("FAIL st_clear_keeps got %h want 012c", got[100]);
        end
    endtask

`ifdef FRAME_CHECKSUM_EN
    task automatic test_checksum();
        fill(1);
        drain(0);
        checks++;
        if (got_n !== 257) begin errors++; $display("FAIL cs_count got %0d want 257", got_n); end
        checks++;
        if (got[256] !== 16'h0100) begin
            errors++; $display("FAIL cs_word got %h want 0100", got[256]);
        end
        checks++;
        if (nlast !== 1 || last_idx !== 256) begin
            errors++; $display("FAIL cs_last got n=%0d idx=%0d want n=1 idx=256", nlast, last_idx);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
        test_sync_err();
        test_backpressure();
        test_overflow();
        test_abort();
        test_stale();
`ifdef FRAME_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
